// File: rtl/alu_operand_stage.sv
`default_nettype none
// ============================================================================
// Module   : alu_operand_stage
// Purpose  : ALU issue stage with operand formation, RAW interlock, and output register.
// Revision : 1.0
// ============================================================================
module alu_operand_stage #(
    parameter int DATA_W = 64,
    parameter int NREGS  = 32,
    parameter int LIT_W  = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_opcode,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [LIT_W-1:0]  in_lit,
    output logic [4:0]        rf_rd_addr,
    output logic [4:0]        rf_rs_addr,
    output logic [4:0]        rf_rt_addr,
    input  logic [DATA_W-1:0] rf_rd_data,
    input  logic [DATA_W-1:0] rf_rs_data,
    input  logic [DATA_W-1:0] rf_rt_data,
    input  logic              wb_en,
    input  logic [4:0]        wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [4:0]        out_opcode,
    output logic [4:0]        out_rd,
    output logic [DATA_W-1:0] out_param1,
    output logic [DATA_W-1:0] out_param2,
    output logic              out_illegal,
    output logic [31:0]       stall_cnt
);

    localparam logic [1:0] c_CLS_ILL = 2'd0;
    localparam logic [1:0] c_CLS_RR  = 2'd1;
    localparam logic [1:0] c_CLS_RI  = 2'd2;
    localparam logic [1:0] c_CLS_UN  = 2'd3;

    logic [NREGS-1:0]  r_pend;
    logic              r_out_valid;
    logic [4:0]        r_out_opcode;
    logic [4:0]        r_out_rd;
    logic [DATA_W-1:0] r_out_param1;
    logic [DATA_W-1:0] r_out_param2;
    logic              r_out_illegal;
    logic [31:0]       r_stall_cnt;

    logic [1:0]        w_cls;
    logic              w_use_rd;
    logic              w_use_rs;
    logic              w_use_rt;
    logic              w_busy_rd;
    logic              w_busy_rs;
    logic              w_busy_rt;
    logic              w_hazard;
    logic              w_in_ready;
    logic              w_accept;
    logic [DATA_W-1:0] w_rd_val;
    logic [DATA_W-1:0] w_rs_val;
    logic [DATA_W-1:0] w_rt_val;
    logic [DATA_W-1:0] w_lit_ext;
    logic [DATA_W-1:0] w_p1;
    logic [DATA_W-1:0] w_p2;
    logic [NREGS-1:0]  w_pend_nxt;

    always_comb begin
        w_cls = c_CLS_ILL;
        case (in_opcode)
            5'h18, 5'h1a, 5'h1c, 5'h1d, 5'h00, 5'h01, 5'h02, 5'h04, 5'h06,
            5'h14, 5'h15, 5'h16, 5'h17:               w_cls = c_CLS_RR;
            5'h19, 5'h1b, 5'h05, 5'h07, 5'h12:        w_cls = c_CLS_RI;
            5'h03, 5'h11:                             w_cls = c_CLS_UN;
            default:                                  w_cls = c_CLS_ILL;
        endcase
    end

    assign w_use_rd = (w_cls == c_CLS_RI);
    assign w_use_rs = (w_cls == c_CLS_RR) || (w_cls == c_CLS_UN);
    assign w_use_rt = (w_cls == c_CLS_RR);

    // Same-cycle writeback is forwarded, so it both supplies data and lifts the interlock.
    assign w_rd_val = (wb_en && wb_addr == in_rd) ? wb_data : rf_rd_data;
    assign w_rs_val = (wb_en && wb_addr == in_rs) ? wb_data : rf_rs_data;
    assign w_rt_val = (wb_en && wb_addr == in_rt) ? wb_data : rf_rt_data;

    assign w_busy_rd = r_pend[in_rd] && !(wb_en && wb_addr == in_rd);
    assign w_busy_rs = r_pend[in_rs] && !(wb_en && wb_addr == in_rs);
    assign w_busy_rt = r_pend[in_rt] && !(wb_en && wb_addr == in_rt);

    assign w_hazard   = (w_use_rd && w_busy_rd) || (w_use_rs && w_busy_rs) ||
                        (w_use_rt && w_busy_rt);
    assign w_in_ready = (!r_out_valid || out_ready) && !w_hazard;
    assign w_accept   = in_valid && w_in_ready;
    assign w_lit_ext  = {{(DATA_W-LIT_W){1'b0}}, in_lit};

    always_comb begin
        w_p1 = '0;
        w_p2 = '0;
        case (w_cls)
            c_CLS_RR: begin
                w_p1 = w_rs_val;
                w_p2 = w_rt_val;
            end
            c_CLS_RI: begin
                w_p1 = w_rd_val;
                w_p2 = w_lit_ext;
            end
            c_CLS_UN: begin
                w_p1 = w_rs_val;
            end
            default: begin
                w_p1 = '0;
                w_p2 = '0;
            end
        endcase
    end

    // Set is applied after clear so a new producer wins over a retiring one.
    always_comb begin
        w_pend_nxt = r_pend;
        if (wb_en) begin
            w_pend_nxt[wb_addr] = 1'b0;
        end
        if (w_accept && (w_cls != c_CLS_ILL)) begin
            w_pend_nxt[in_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend        <= '0;
            r_out_valid   <= 1'b0;
            r_out_opcode  <= '0;
            r_out_rd      <= '0;
            r_out_param1  <= '0;
            r_out_param2  <= '0;
            r_out_illegal <= 1'b0;
            r_stall_cnt   <= '0;
        end else begin
            r_pend <= w_pend_nxt;
            if (w_accept) begin
                r_out_valid   <= 1'b1;
                r_out_opcode  <= in_opcode;
                r_out_rd      <= in_rd;
                r_out_param1  <= w_p1;
                r_out_param2  <= w_p2;
                r_out_illegal <= (w_cls == c_CLS_ILL);
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (in_valid && !w_in_ready && (r_stall_cnt != 32'hFFFF_FFFF)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
        end
    end

    assign in_ready    = w_in_ready;
    assign rf_rd_addr  = in_rd;
    assign rf_rs_addr  = in_rs;
    assign rf_rt_addr  = in_rt;
    assign out_valid   = r_out_valid;
    assign out_opcode  = r_out_opcode;
    assign out_rd      = r_out_rd;
    assign out_param1  = r_out_param1;
    assign out_param2  = r_out_param2;
    assign out_illegal = r_out_illegal;
    assign stall_cnt   = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_alu_operand_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_operand_stage
// Purpose  : Directed scoreboard bench for alu_operand_stage.
// Revision : 1.0
// ============================================================================
module tb_alu_operand_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_opcode, in_rd, in_rs, in_rt;
    logic [11:0] in_lit;
    logic [4:0]  rf_rd_addr, rf_rs_addr, rf_rt_addr;
    logic [63:0] rf_rd_data, rf_rs_data, rf_rt_data;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [63:0] wb_data;
    logic        out_valid, out_ready;
    logic [4:0]  out_opcode, out_rd;
    logic [63:0] out_param1, out_param2;
    logic        out_illegal;
    logic [31:0] stall_cnt;

    typedef struct packed {
        logic [4:0]  op;
        logic [4:0]  rd;
        logic [63:0] p1;
        logic [63:0] p2;
        logic        ill;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    alu_operand_stage #(.DATA_W(64), .NREGS(32), .LIT_W(12)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_rd(in_rd), .in_rs(in_rs), .in_rt(in_rt),
        .in_lit(in_lit),
        .rf_rd_addr(rf_rd_addr), .rf_rs_addr(rf_rs_addr), .rf_rt_addr(rf_rt_addr),
        .rf_rd_data(rf_rd_data), .rf_rs_data(rf_rs_data), .rf_rt_data(rf_rt_data),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_opcode(out_opcode), .out_rd(out_rd),
        .out_param1(out_param1), .out_param2(out_param2),
        .out_illegal(out_illegal), .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] op, input logic [4:0] rd,
                         input logic [4:0] rs, input logic [4:0] rt, input logic [11:0] lit);
        in_valid  = v;
        in_opcode = op;
        in_rd     = rd;
        in_rs     = rs;
        in_rt     = rt;
        in_lit    = lit;
    endtask

    // Output monitor: every handshake consumes the oldest expected transaction.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (q.size() == 0) begin
                chk("unexpected_out", 64'(out_opcode), 64'h3f);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("sb_opcode", 64'(out_opcode), 64'(e.op));
                chk("sb_rd", 64'(out_rd), 64'(e.rd));
                chk("sb_p1", out_param1, e.p1);
                chk("sb_p2", out_param2, e.p2);
                chk("sb_illegal", 64'(out_illegal), 64'(e.ill));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; out_ready = 1'b1; wb_en = 1'b0; wb_addr = '0; wb_data = '0;
        rf_rd_data = '0; rf_rs_data = '0; rf_rt_data = '0;
        drive(1'b0, 5'h00, 5'd0, 5'd0, 5'd0, 12'h000);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_p1", out_param1, 64'd0);
        chk("rst_illegal", 64'(out_illegal), 64'd0);
        chk("rst_stall", 64'(stall_cnt), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        tick();
        rst_n = 1'b1;

        // 1: RI with literal
        tick();
        drive(1'b1, 5'h05, 5'd3, 5'd0, 5'd0, 12'h005);
        rf_rd_data = 64'd10;
        @(negedge clk);
        chk("t1_in_ready", 64'(in_ready), 64'd1);
        q.push_back('{op: 5'h05, rd: 5'd3, p1: 64'd10, p2: 64'd5, ill: 1'b0});
        tick();
        drive(1'b0, 5'h03, 5'd0, 5'd3, 5'd0, 12'h000);
        @(negedge clk);
        chk("t1_out_valid", 64'(out_valid), 64'd1);
        chk("t1_p1", out_param1, 64'd10);
        chk("t1_p2", out_param2, 64'd5);
        chk("t1_pend3_blocks", 64'(in_ready), 64'd0);
        tick();
        wb_en = 1'b1; wb_addr = 5'd3; wb_data = 64'd77;
        @(negedge clk);
        chk("t1_wb_bypass_ready", 64'(in_ready), 64'd1);
        tick();
        wb_en = 1'b0;
        @(negedge clk);
        chk("t1_pend3_cleared", 64'(in_ready), 64'd1);

        // 2: RR with downstream backpressure
        tick();
        drive(1'b1, 5'h00, 5'd1, 5'd2, 5'd3, 12'h000);
        rf_rs_data = 64'd7; rf_rt_data = 64'd9; out_ready = 1'b0;
        @(negedge clk);
        chk("t2_in_ready", 64'(in_ready), 64'd1);
        q.push_back('{op: 5'h00, rd: 5'd1, p1: 64'd7, p2: 64'd9, ill: 1'b0});
        tick();
        drive(1'b1, 5'h01, 5'd6, 5'd2, 5'd7, 12'h000);
        rf_rt_data = 64'd100;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t2_hold_valid", 64'(out_valid), 64'd1);
            chk("t2_hold_p1", out_param1, 64'd7);
            chk("t2_hold_p2", out_param2, 64'd9);
            chk("t2_in_ready_low", 64'(in_ready), 64'd0);
            chk("t2_stall_cnt", 64'(stall_cnt), 64'(i));
            tick();
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("t2_stall_final", 64'(stall_cnt), 64'd3);
        chk("t2_release_ready", 64'(in_ready), 64'd1);
        q.push_back('{op: 5'h01, rd: 5'd6, p1: 64'd7, p2: 64'd100, ill: 1'b0});
        tick();
        drive(1'b0, 5'h00, 5'd0, 5'd0, 5'd0, 12'h000);
        @(negedge clk);

        // 3: RAW interlock resolved by same-cycle writeback
        tick();
        drive(1'b1, 5'h00, 5'd4, 5'd2, 5'd3, 12'h000);
        rf_rs_data = 64'd7; rf_rt_data = 64'd9;
        @(negedge clk);
        chk("t3_add_ready", 64'(in_ready), 64'd1);
        q.push_back('{op: 5'h00, rd: 5'd4, p1: 64'd7, p2: 64'd9, ill: 1'b0});
        tick();
        drive(1'b1, 5'h01, 5'd8, 5'd4, 5'd2, 12'h000);
        rf_rs_data = 64'd55; rf_rt_data = 64'd7;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t3_hazard_block", 64'(in_ready), 64'd0);
            tick();
        end
        wb_en = 1'b1; wb_addr = 5'd4; wb_data = 64'hDEAD_BEEF_0000_1234;
        @(negedge clk);
        chk("t3_stall_cnt", 64'(stall_cnt), 64'd6);
        chk("t3_wb_ready", 64'(in_ready), 64'd1);
        q.push_back('{op: 5'h01, rd: 5'd8, p1: 64'hDEAD_BEEF_0000_1234, p2: 64'd7, ill: 1'b0});
        tick();
        wb_en = 1'b0;
        drive(1'b0, 5'h00, 5'd0, 5'd0, 5'd0, 12'h000);
        @(negedge clk);
        chk("t3_fwd_p1", out_param1, 64'hDEAD_BEEF_0000_1234);

        // 4: writeback and new producer collide on r5
        tick();
        wb_en = 1'b1; wb_addr = 5'd5; wb_data = 64'd1;
        drive(1'b1, 5'h02, 5'd5, 5'd2, 5'd3, 12'h000);
        rf_rs_data = 64'd7; rf_rt_data = 64'd9;
        @(negedge clk);
        chk("t4_ready", 64'(in_ready), 64'd1);
        q.push_back('{op: 5'h02, rd: 5'd5, p1: 64'd7, p2: 64'd9, ill: 1'b0});
        tick();
        wb_en = 1'b0;
        drive(1'b0, 5'h03, 5'd0, 5'd5, 5'd0, 12'h000);
        @(negedge clk);
        chk("t4_pend5_set", 64'(in_ready), 64'd0);

        // 5: illegal opcode
        tick();
        drive(1'b1, 5'h1f, 5'd9, 5'd5, 5'd5, 12'hABC);
        @(negedge clk);
        chk("t5_ready", 64'(in_ready), 64'd1);
        q.push_back('{op: 5'h1f, rd: 5'd9, p1: 64'd0, p2: 64'd0, ill: 1'b1});
        tick();
        drive(1'b0, 5'h05, 5'd9, 5'd0, 5'd0, 12'h000);
        @(negedge clk);
        chk("t5_illegal", 64'(out_illegal), 64'd1);
        chk("t5_p1", out_param1, 64'd0);
        chk("t5_p2", out_param2, 64'd0);
        chk("t5_no_pend9", 64'(in_ready), 64'd1);
        tick();
        drive(1'b0, 5'h03, 5'd0, 5'd5, 5'd0, 12'h000);
        @(negedge clk);
        chk("t5_pend5_kept", 64'(in_ready), 64'd0);

        // 6: asynchronous reset while holding an instruction
        tick();
        drive(1'b1, 5'h11, 5'd10, 5'd2, 5'd0, 12'h000);
        out_ready = 1'b0;
        @(negedge clk);
        chk("t6_ready", 64'(in_ready), 64'd1);
        tick();
        drive(1'b0, 5'h03, 5'd0, 5'd5, 5'd0, 12'h000);
        @(negedge clk);
        chk("t6_held_valid", 64'(out_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", 64'(out_valid), 64'd0);
        chk("t6_rst_p1", out_param1, 64'd0);
        chk("t6_rst_pend", 64'(in_ready), 64'd1);
        chk("t6_rst_stall", 64'(stall_cnt), 64'd0);
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (2) tick();
        chk("sb_empty", 64'(q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
